// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch
// Purpose  : Instruction fetch stage with a loadable 32-word instruction
//            memory, IDLE/RUN/HALT sequencing and a retired-instruction count.
// Revision : 1.0
// ============================================================================
module instr_fetch (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        stall,
    input  logic        branch,
    input  logic        jump,
    input  logic        zero,
    input  logic        load_en,
    input  logic [4:0]  load_addr,
    input  logic [31:0] load_data,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic        running,
    output logic [15:0] retired
);

    localparam logic [1:0]  c_IDLE     = 2'd0;
    localparam logic [1:0]  c_RUN      = 2'd1;
    localparam logic [1:0]  c_HALT     = 2'd2;
    localparam logic [31:0] c_HALT_OP  = 32'hFFFF_FFFF;
    localparam logic [15:0] c_RET_MAX  = 16'hFFFF;

    logic [1:0]  r_state;
    logic [31:0] r_pc;
    logic [15:0] r_retired;
    logic [31:0] r_mem [32];

    logic [31:0] w_word;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_branch_off;
    logic [31:0] w_next_pc;
    logic        w_in_run;

    // Only the word index bits address memory, so fetch wraps every 128 bytes.
    assign w_word       = r_mem[r_pc[6:2]];
    assign w_in_run     = (r_state == c_RUN);
    assign w_pc_plus4   = r_pc + 32'd4;
    assign w_branch_off = {{14{w_word[15]}}, w_word[15:0], 2'b00};

    always_comb begin
        w_next_pc = w_pc_plus4;
        if (jump) begin
            w_next_pc = {w_pc_plus4[31:28], w_word[25:0], 2'b00};
        end else if (branch && zero) begin
            w_next_pc = w_pc_plus4 + w_branch_off;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= c_IDLE;
            r_pc      <= 32'd0;
            r_retired <= 16'd0;
        end else begin
            case (r_state)
                c_IDLE, c_HALT: begin
                    if (start) begin
                        r_state   <= c_RUN;
                        r_pc      <= 32'd0;
                        r_retired <= 16'd0;
                    end
                end
                c_RUN: begin
                    if (!stall) begin
                        // The halt word itself is not retired and its pc is kept.
                        if (w_word == c_HALT_OP) begin
                            r_state <= c_HALT;
                        end else begin
                            r_pc <= w_next_pc;
                            if (r_retired != c_RET_MAX) begin
                                r_retired <= r_retired + 16'd1;
                            end
                        end
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    // Memory has no reset so a program survives a reset and can be rerun.
    always_ff @(posedge clk) begin
        if (!reset && load_en && !w_in_run) begin
            r_mem[load_addr] <= load_data;
        end
    end

    assign pc       = r_pc;
    assign pc_plus4 = w_pc_plus4;
    assign instr    = w_in_run ? w_word : 32'h0000_0000;
    assign opcode   = instr[31:26];
    assign running  = w_in_run;
    assign retired  = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch
// Purpose  : Scoreboard testbench for instr_fetch.
// Revision : 1.0
// ============================================================================
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        reset, start, stall, branch, jump, zero, load_en;
    logic [4:0]  load_addr;
    logic [31:0] load_data;
    logic [31:0] pc, pc_plus4, instr;
    logic [5:0]  opcode;
    logic        running;
    logic [15:0] retired;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [15:0] retired;
        logic        running;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    instr_fetch dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .stall     (stall),
        .branch    (branch),
        .jump      (jump),
        .zero      (zero),
        .load_en   (load_en),
        .load_addr (load_addr),
        .load_data (load_data),
        .pc        (pc),
        .pc_plus4  (pc_plus4),
        .instr     (instr),
        .opcode    (opcode),
        .running   (running),
        .retired   (retired)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] p, input logic [31:0] ins,
                        input logic [15:0] r, input logic run);
        exp_t e;
        e.pc = p; e.instr = ins; e.retired = r; e.running = run;
        q.push_back(e);
    endtask

    task automatic clear_inputs;
        reset = 1'b0; start = 1'b0; stall = 1'b0; branch = 1'b0;
        jump = 1'b0; zero = 1'b0; load_en = 1'b0;
        load_addr = 5'd0; load_data = 32'd0;
    endtask

    task automatic do_reset;
        clear_inputs();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic load_word(input logic [4:0] a, input logic [31:0] d);
        load_en = 1'b1; load_addr = a; load_data = d;
        step();
        load_en = 1'b0;
    endtask

    task automatic test_reset;
        exp_t e;
        clear_inputs();
        for (int i = 0; i < 2; i++) begin
            reset = 1'b1; start = 1'b1;
            push(32'd0, 32'd0, 16'd0, 1'b0);
            step();
            e = q.pop_front();
            total++;
            if (pc !== e.pc || instr !== e.instr || retired !== e.retired || running !== e.running ||
                opcode !== e.instr[31:26] || pc_plus4 !== e.pc + 32'd4) begin
                bad++;
                $display("FAIL reset[%0d]: got pc=%h instr=%h op=%b ret=%0d run=%b p4=%h want pc=%h instr=%h ret=%0d run=%b",
                         i, pc, instr, opcode, retired, running, pc_plus4, e.pc, e.instr, e.retired, e.running);
            end
        end
        clear_inputs();
    endtask

    task automatic test_sequential;
        exp_t e;
        do_reset();
        load_word(5'd0, 32'h8C00_0000);
        load_word(5'd1, 32'hAC00_0000);
        load_word(5'd2, 32'hFFFF_FFFF);
        for (int i = 0; i < 7; i++) begin
            case (i)
                0: begin start = 1'b1; push(32'd0, 32'h8C00_0000, 16'd0, 1'b1); end
                1: begin start = 1'b1; push(32'd4, 32'hAC00_0000, 16'd1, 1'b1); end
                2: begin start = 1'b0; push(32'd8, 32'hFFFF_FFFF, 16'd2, 1'b1); end
                3: push(32'd8, 32'd0, 16'd2, 1'b0);
                4: push(32'd8, 32'd0, 16'd2, 1'b0);
                5: begin start = 1'b1; push(32'd0, 32'h8C00_0000, 16'd0, 1'b1); end
                default: begin start = 1'b0; push(32'd4, 32'hAC00_0000, 16'd1, 1'b1); end
            endcase
            step();
            e = q.pop_front();
            total++;
            if (pc !== e.pc || instr !== e.instr || retired !== e.retired || running !== e.running ||
                opcode !== e.instr[31:26] || pc_plus4 !== e.pc + 32'd4) begin
                bad++;
                $display("FAIL sequential[%0d]: got pc=%h instr=%h op=%b ret=%0d run=%b p4=%h want pc=%h instr=%h ret=%0d run=%b",
                         i, pc, instr, opcode, retired, running, pc_plus4, e.pc, e.instr, e.retired, e.running);
            end
        end
    endtask

    task automatic test_branch;
        exp_t e;
        do_reset();
        load_word(5'd0, 32'h1000_0003);
        load_word(5'd1, 32'h0000_0000);
        load_word(5'd2, 32'hFFFF_FFFF);
        load_word(5'd4, 32'h0000_0000);
        for (int i = 0; i < 7; i++) begin
            case (i)
                0: begin start = 1'b1; branch = 1'b1; zero = 1'b1; push(32'd0, 32'h1000_0003, 16'd0, 1'b1); end
                1: begin start = 1'b0; push(32'd16, 32'd0, 16'd1, 1'b1); end
                2: begin branch = 1'b0; zero = 1'b0; reset = 1'b1; push(32'd0, 32'd0, 16'd0, 1'b0); end
                3: begin reset = 1'b0; start = 1'b1; branch = 1'b1; push(32'd0, 32'h1000_0003, 16'd0, 1'b1); end
                4: begin start = 1'b0; push(32'd4, 32'd0, 16'd1, 1'b1); end
                5: begin branch = 1'b0; zero = 1'b1; push(32'd8, 32'hFFFF_FFFF, 16'd2, 1'b1); end
                default: push(32'd8, 32'd0, 16'd2, 1'b0);
            endcase
            step();
            e = q.pop_front();
            total++;
            if (pc !== e.pc || instr !== e.instr || retired !== e.retired || running !== e.running ||
                opcode !== e.instr[31:26] || pc_plus4 !== e.pc + 32'd4) begin
                bad++;
                $display("FAIL branch[%0d]: got pc=%h instr=%h op=%b ret=%0d run=%b p4=%h want pc=%h instr=%h ret=%0d run=%b",
                         i, pc, instr, opcode, retired, running, pc_plus4, e.pc, e.instr, e.retired, e.running);
            end
        end
        clear_inputs();
    endtask

    task automatic test_jump;
        exp_t e;
        do_reset();
        load_word(5'd0, 32'h0800_0005);
        load_word(5'd5, 32'h0000_0000);
        load_word(5'd6, 32'hFFFF_FFFF);
        for (int i = 0; i < 4; i++) begin
            case (i)
                0: begin start = 1'b1; jump = 1'b1; branch = 1'b1; zero = 1'b1;
                         push(32'd0, 32'h0800_0005, 16'd0, 1'b1); end
                1: begin start = 1'b0; push(32'd20, 32'd0, 16'd1, 1'b1); end
                2: begin jump = 1'b0; branch = 1'b0; zero = 1'b0; push(32'd24, 32'hFFFF_FFFF, 16'd2, 1'b1); end
                default: push(32'd24, 32'd0, 16'd2, 1'b0);
            endcase
            step();
            e = q.pop_front();
            total++;
            if (pc !== e.pc || instr !== e.instr || retired !== e.retired || running !== e.running ||
                opcode !== e.instr[31:26] || pc_plus4 !== e.pc + 32'd4) begin
                bad++;
                $display("FAIL jump[%0d]: got pc=%h instr=%h op=%b ret=%0d run=%b p4=%h want pc=%h instr=%h ret=%0d run=%b",
                         i, pc, instr, opcode, retired, running, pc_plus4, e.pc, e.instr, e.retired, e.running);
            end
        end
    endtask

    task automatic test_stall;
        exp_t e;
        do_reset();
        load_word(5'd0, 32'h0000_0000);
        load_word(5'd1, 32'hFFFF_FFFF);
        for (int i = 0; i < 6; i++) begin
            case (i)
                0: begin start = 1'b1; push(32'd0, 32'd0, 16'd0, 1'b1); end
                1: begin start = 1'b0; push(32'd4, 32'hFFFF_FFFF, 16'd1, 1'b1); end
                2, 3, 4: begin stall = 1'b1; push(32'd4, 32'hFFFF_FFFF, 16'd1, 1'b1); end
                default: begin stall = 1'b0; push(32'd4, 32'd0, 16'd1, 1'b0); end
            endcase
            step();
            e = q.pop_front();
            total++;
            if (pc !== e.pc || instr !== e.instr || retired !== e.retired || running !== e.running ||
                opcode !== e.instr[31:26] || pc_plus4 !== e.pc + 32'd4) begin
                bad++;
                $display("FAIL stall[%0d]: got pc=%h instr=%h op=%b ret=%0d run=%b p4=%h want pc=%h instr=%h ret=%0d run=%b",
                         i, pc, instr, opcode, retired, running, pc_plus4, e.pc, e.instr, e.retired, e.running);
            end
        end
    endtask

    task automatic test_reset_mid_run;
        exp_t e;
        do_reset();
        load_word(5'd0, 32'h2000_0001);
        load_word(5'd1, 32'h2000_0002);
        load_word(5'd2, 32'h2000_0003);
        load_word(5'd3, 32'h2000_0004);
        load_word(5'd4, 32'hFFFF_FFFF);
        for (int i = 0; i < 7; i++) begin
            case (i)
                0: begin start = 1'b1; push(32'd0, 32'h2000_0001, 16'd0, 1'b1); end
                1: begin start = 1'b0; push(32'd4, 32'h2000_0002, 16'd1, 1'b1); end
                2: push(32'd8, 32'h2000_0003, 16'd2, 1'b1);
                3: push(32'd12, 32'h2000_0004, 16'd3, 1'b1);
                4: begin reset = 1'b1; start = 1'b1; stall = 1'b1; load_en = 1'b1;
                         load_addr = 5'd0; load_data = 32'hFFFF_FFFF;
                         push(32'd0, 32'd0, 16'd0, 1'b0); end
                5: begin reset = 1'b0; stall = 1'b0; load_en = 1'b0;
                         push(32'd0, 32'h2000_0001, 16'd0, 1'b1); end
                default: begin start = 1'b0; push(32'd4, 32'h2000_0002, 16'd1, 1'b1); end
            endcase
            step();
            e = q.pop_front();
            total++;
            if (pc !== e.pc || instr !== e.instr || retired !== e.retired || running !== e.running ||
                opcode !== e.instr[31:26] || pc_plus4 !== e.pc + 32'd4) begin
                bad++;
                $display("FAIL reset_mid_run[%0d]: got pc=%h instr=%h op=%b ret=%0d run=%b p4=%h want pc=%h instr=%h ret=%0d run=%b",
                         i, pc, instr, opcode, retired, running, pc_plus4, e.pc, e.instr, e.retired, e.running);
            end
        end
        clear_inputs();
    endtask

    task automatic test_load_block_wrap;
        exp_t e;
        do_reset();
        load_word(5'd0, 32'h0800_001F);
        load_word(5'd1, 32'h2000_0002);
        load_word(5'd31, 32'h0000_0000);
        for (int i = 0; i < 4; i++) begin
            case (i)
                0: begin start = 1'b1; push(32'd0, 32'h0800_001F, 16'd0, 1'b1); end
                1: begin start = 1'b0; jump = 1'b1; load_en = 1'b1; load_addr = 5'd31;
                         load_data = 32'hFFFF_FFFF; push(32'd124, 32'd0, 16'd1, 1'b1); end
                2: begin jump = 1'b0; load_addr = 5'd0; push(32'd128, 32'h0800_001F, 16'd2, 1'b1); end
                default: begin load_en = 1'b0; push(32'd132, 32'h2000_0002, 16'd3, 1'b1); end
            endcase
            step();
            e = q.pop_front();
            total++;
            if (pc !== e.pc || instr !== e.instr || retired !== e.retired || running !== e.running ||
                opcode !== e.instr[31:26] || pc_plus4 !== e.pc + 32'd4) begin
                bad++;
                $display("FAIL load_block_wrap[%0d]: got pc=%h instr=%h op=%b ret=%0d run=%b p4=%h want pc=%h instr=%h ret=%0d run=%b",
                         i, pc, instr, opcode, retired, running, pc_plus4, e.pc, e.instr, e.retired, e.running);
            end
        end
        clear_inputs();
    endtask

    task automatic test_back_to_back;
        exp_t e;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            case (i)
                0: begin start = 1'b1; load_en = 1'b1; load_addr = 5'd0; load_data = 32'hFFFF_FFFF;
                         push(32'd0, 32'hFFFF_FFFF, 16'd0, 1'b1); end
                1: begin start = 1'b0; load_en = 1'b0; push(32'd0, 32'd0, 16'd0, 1'b0); end
                2: begin start = 1'b1; load_en = 1'b1; load_data = 32'h0000_0000;
                         push(32'd0, 32'd0, 16'd0, 1'b1); end
                default: begin start = 1'b0; load_en = 1'b0; push(32'd4, 32'h2000_0002, 16'd1, 1'b1); end
            endcase
            step();
            e = q.pop_front();
            total++;
            if (pc !== e.pc || instr !== e.instr || retired !== e.retired || running !== e.running ||
                opcode !== e.instr[31:26] || pc_plus4 !== e.pc + 32'd4) begin
                bad++;
                $display("FAIL back_to_back[%0d]: got pc=%h instr=%h op=%b ret=%0d run=%b p4=%h want pc=%h instr=%h ret=%0d run=%b",
                         i, pc, instr, opcode, retired, running, pc_plus4, e.pc, e.instr, e.retired, e.running);
            end
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_sequential();
        test_branch();
        test_jump();
        test_stall();
        test_reset_mid_run();
        test_load_block_wrap();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
